// File: rtl/ysyx_22040383_ex_muldiv_pkg.sv
// Shared widths, funct3 encodings and FSM states for the EX-stage RV64M mul/div unit.
package ysyx_22040383_ex_muldiv_pkg;

    localparam int XLEN      = 64;
    localparam int WLEN      = 32;
    localparam int MUL_ITERS = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        SPECIAL = 2'd2,
        DONE    = 2'd3
    } md_state_e;

    function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22040383_md_sign_fix.sv
// Conditional two's-complement negate: operand magnitude on the way in, sign restore on the way out.
module ysyx_22040383_md_sign_fix #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/ysyx_22040383_ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage; stalls upstream while busy.
// Define YSYX_22040383_FAST_MUL_EN to replace the shift-add loop with a one-cycle multiplier.
module ysyx_22040383_ex_muldiv
    import ysyx_22040383_ex_muldiv_pkg::*;
(
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            md_valid,
    input  logic [2:0]      md_op,
    input  logic            md_word_op,
    input  logic [XLEN-1:0] md_src_a,
    input  logic [XLEN-1:0] md_src_b,
    input  logic            md_flush,
    output logic            md_stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    md_state_e         state;
    md_op_e            op_q;
    logic              word_q;
    logic              res_neg;
    logic [5:0]        cnt;
    logic [5:0]        cnt_last;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] acc;

    md_op_e          op_in;
    logic            signed_a, signed_b, a_neg, b_neg, in_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;

    assign op_in    = md_op_e'(md_op);
    assign signed_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign signed_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);

    assign a_ext = !md_word_op ? md_src_a :
                   signed_a    ? sext_word(md_src_a[WLEN-1:0]) : {{(XLEN-WLEN){1'b0}}, md_src_a[WLEN-1:0]};
    assign b_ext = !md_word_op ? md_src_b :
                   signed_b    ? sext_word(md_src_b[WLEN-1:0]) : {{(XLEN-WLEN){1'b0}}, md_src_b[WLEN-1:0]};

    assign a_neg  = signed_a & a_ext[XLEN-1];
    assign b_neg  = signed_b & b_ext[XLEN-1];
    // Remainder follows the dividend; quotient and products take the XOR of both signs.
    assign in_neg = (md_op[2] & md_op[1]) ? a_neg : (a_neg ^ b_neg);

    ysyx_22040383_md_sign_fix #(.W(XLEN)) u_a_fix (.value(a_ext), .negate(a_neg), .result(a_mag));
    ysyx_22040383_md_sign_fix #(.W(XLEN)) u_b_fix (.value(b_ext), .negate(b_neg), .result(b_mag));

    assign min_val  = md_word_op ? sext_word({1'b1, {(WLEN-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = md_op[2] & (b_ext == '0);
    assign div_ovf  = md_op[2] & signed_b & (a_ext == min_val) & (&b_ext);

`ifdef YSYX_22040383_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    // One iteration: shift-add multiply walks right, restoring divide walks left.
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] step_next;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[XLEN-1:0] - opnd;
    assign step_next = !op_q[2] ? {mul_sum, acc[XLEN-1:1]} :
                       div_ge   ? {div_sub, acc[XLEN-2:0], 1'b1} :
                                  {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};

    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_raw, div_fixed, res_wide, final_res;

    assign div_raw = op_q[1] ?
        (word_q ? {{(XLEN-WLEN){1'b0}}, acc[XLEN+WLEN-1:XLEN]} : acc[2*XLEN-1:XLEN]) :
        (word_q ? {{(XLEN-WLEN){1'b0}}, acc[WLEN-1:0]}         : acc[XLEN-1:0]);

    ysyx_22040383_md_sign_fix #(.W(2*XLEN)) u_prod_fix (.value(acc), .negate(res_neg), .result(prod_fixed));
    ysyx_22040383_md_sign_fix #(.W(XLEN))   u_div_fix  (.value(div_raw), .negate(res_neg), .result(div_fixed));

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        res_wide = div_fixed;
        if (!op_q[2]) begin
            if (op_q == OP_MUL)
                res_wide = word_q ? {{(XLEN-WLEN){1'b0}}, prod_fixed[XLEN-1:WLEN]} : prod_fixed[XLEN-1:0];
            else
                res_wide = prod_fixed[2*XLEN-1:XLEN];
        end
    end

    assign final_res = word_q ? sext_word(res_wide[WLEN-1:0]) : res_wide;
    assign md_result = (state == DONE) ? final_res : result_q;
    assign md_stall  = md_valid && (state != DONE);

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= IDLE;
            md_done  <= 1'b0;
            result_q <= '0;
            cnt      <= '0;
            cnt_last <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= OP_MUL;
            word_q   <= 1'b0;
            res_neg  <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_valid && !md_flush) begin
                        op_q     <= op_in;
                        word_q   <= md_word_op;
                        cnt      <= '0;
                        cnt_last <= md_word_op ? 6'(MUL_ITERS/2 - 1) : 6'(MUL_ITERS - 1);
                        if (div_zero) begin
                            acc     <= {a_ext, {XLEN{1'b1}}};
                            res_neg <= 1'b0;
                            state   <= SPECIAL;
                        end else if (div_ovf) begin
                            acc     <= {{XLEN{1'b0}}, a_ext};
                            res_neg <= 1'b0;
                            state   <= SPECIAL;
`ifdef YSYX_22040383_FAST_MUL_EN
                        end else if (!md_op[2]) begin
                            acc     <= md_word_op ? {fast_prod[2*XLEN-WLEN-1:0], {WLEN{1'b0}}} : fast_prod;
                            res_neg <= in_neg;
                            state   <= DONE;
                            md_done <= 1'b1;
`endif
                        end else begin
                            // Word divides park the dividend in the top half so 32 shifts consume it.
                            opnd    <= md_op[2] ? b_mag : a_mag;
                            acc     <= !md_op[2]  ? {{XLEN{1'b0}}, b_mag} :
                                       md_word_op ? {{XLEN{1'b0}}, a_mag[WLEN-1:0], {WLEN{1'b0}}} :
                                                    {{XLEN{1'b0}}, a_mag};
                            res_neg <= in_neg;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (md_flush || !md_valid) begin
                        state <= IDLE;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == cnt_last) begin
                            state   <= DONE;
                            md_done <= 1'b1;
                        end
                    end
                end
                SPECIAL: begin
                    if (md_flush || !md_valid) begin
                        state <= IDLE;
                    end else begin
                        state   <= DONE;
                        md_done <= 1'b1;
                    end
                end
                DONE: begin
                    result_q <= final_res;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040383_ex_muldiv.sv
// Self-checking bench: directed corner cases plus random ops against an arithmetic reference model.
module tb_ysyx_22040383_ex_muldiv;

    logic        sys_clk    = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        md_valid   = 1'b0;
    logic [2:0]  md_op      = 3'd0;
    logic        md_word_op = 1'b0;
    logic [63:0] md_src_a   = '0;
    logic [63:0] md_src_b   = '0;
    logic        md_flush   = 1'b0;
    logic        md_stall;
    logic        md_done;
    logic [63:0] md_result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    ysyx_22040383_ex_muldiv dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .md_valid  (md_valid),
        .md_op     (md_op),
        .md_word_op(md_word_op),
        .md_src_a  (md_src_a),
        .md_src_b  (md_src_b),
        .md_flush  (md_flush),
        .md_stall  (md_stall),
        .md_done   (md_done),
        .md_result (md_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Architectural result of an RV64M instruction, straight from the ISA rules.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic word,
                                           input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ps;
        logic [127:0]        pu;
        logic [63:0]         r;
        logic [31:0]         r32;
        longint              sa64, sb64;
        int                  sa, sb;
        int unsigned         ua, ub;
        logic                ovf64, ovf32;
        r = '0; r32 = '0;
        sa64 = a; sb64 = b; sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        if (word) begin
            case (op)
                3'd4:    r32 = (ub == 0) ? 32'hFFFF_FFFF : ovf32 ? a[31:0] : 32'(sa / sb);
                3'd5:    r32 = (ub == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
                3'd6:    r32 = (ub == 0) ? a[31:0] : ovf32 ? 32'd0 : 32'(sa % sb);
                3'd7:    r32 = (ub == 0) ? a[31:0] : 32'(ua % ub);
                default: r32 = a[31:0] * b[31:0];
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (op)
            3'd0: r = a * b;
            3'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
            3'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});       r = ps[127:64]; end
            3'd3: begin pu = {64'd0, a} * {64'd0, b};                                r = pu[127:64]; end
            3'd4: r = (b == 0) ? '1 : ovf64 ? a : 64'(sa64 / sb64);
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: r = (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa64 % sb64);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Cycles from acceptance to md_done inclusive.
    function automatic int exp_latency(input logic [2:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf, sdiv;
        zero = word ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    : (a == 64'h8000_0000_0000_0000 && b == '1);
        sdiv = (op == 3'd4) || (op == 3'd6);
        if (op[2] && (zero || (sdiv && ovf))) return 3;
`ifdef YSYX_22040383_FAST_MUL_EN
        if (!op[2]) return 2;
`endif
        return word ? 34 : 66;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            5:       return 64'($signed(-$urandom_range(1, 20)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
        md_valid = 1'b1; md_op = op; md_word_op = word; md_src_a = a; md_src_b = b;
    endtask

    // Called right after inputs change on a falling edge; counts cycles up to md_done.
    task automatic wait_done(output int cycles, output int stalls, output logic seen);
        cycles = 0; stalls = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            cycles++;
            if (md_stall) stalls++;
            if (md_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        int   cyc, stl, lat;
        logic seen;
        lat = exp_latency(op, word, a, b);
        @(negedge sys_clk);
        drive(op, word, a, b);
        wait_done(cyc, stl, seen);
        check({tag, "_done"},  64'(seen), 64'd1);
        check({tag, "_lat"},   64'(cyc),  64'(lat));
        check({tag, "_stall"}, 64'(stl),  64'(lat - 1));
        check({tag, "_res"},   md_result, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          cyc, stl, done_cnt;
        logic        seen;
        logic [2:0]  op;
        logic        word;
        logic [63:0] a, b;

        #2 sys_rst = 1'b0;
        #1;
        check("reset_done",   64'(md_done),  64'd0);
        check("reset_result", md_result,     64'd0);
        check("reset_stall",  64'(md_stall), 64'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;

        run_op("mul",      3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulhu",    3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulh",     3'd1, 1'b0, '1, '1, 64'd0);
        run_op("mulhsu",   3'd2, 1'b0, '1, 64'd2, '1);
        run_op("divu0",    3'd5, 1'b0, 64'd100, 64'd0, '1);
        run_op("remu0",    3'd7, 1'b0, 64'd100, 64'd0, 64'd100);
        run_op("divw_ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        run_op("remw_ovf", 3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
        run_op("div",      3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem",      3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1);
        run_op("divw",     3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("remuw",    3'd7, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'd1);

        @(negedge sys_clk);
        md_valid = 1'b0;
        #1;
        check("hold_done", 64'(md_done), 64'd0);
        check("hold_res",  md_result,    64'd1);

        // Flush at CALC cycle 10 with the op still presented: the unit must restart from scratch.
        @(negedge sys_clk);
        drive(3'd5, 1'b0, 64'd1000, 64'd7);
        repeat (10) @(negedge sys_clk);
        md_flush = 1'b1;
        @(negedge sys_clk);
        md_flush = 1'b0;
        wait_done(cyc, stl, seen);
        check("flush_done", 64'(seen), 64'd1);
        check("flush_lat",  64'(cyc),  64'd66);
        check("flush_res",  md_result, 64'd142);

        // Flush coinciding with acceptance blocks it.
        @(negedge sys_clk);
        drive(3'd5, 1'b1, 64'd100, 64'd7);
        md_flush = 1'b1;
        @(negedge sys_clk);
        md_flush = 1'b0;
        wait_done(cyc, stl, seen);
        check("flush_acc_lat", 64'(cyc),  64'd34);
        check("flush_acc_res", md_result, 64'd14);

        // md_valid dropping mid-CALC abandons the op.
        @(negedge sys_clk);
        drive(3'd4, 1'b0, 64'd12345, 64'hFFFF_FFFF_FFFF_FFFB);
        repeat (20) @(negedge sys_clk);
        md_valid = 1'b0;
        done_cnt = 0;
        repeat (80) begin
            @(negedge sys_clk);
            #1;
            if (md_done) done_cnt++;
        end
        check("vdrop_no_done", 64'(done_cnt), 64'd0);
        check("vdrop_hold",    md_result,     64'd14);

        run_op("mulw", 3'd0, 1'b1, 64'd3, 64'd5, 64'd15);

        // Asynchronous reset in the middle of a divide.
        @(negedge sys_clk);
        drive(3'd4, 1'b0, 64'd999, 64'd3);
        repeat (20) @(negedge sys_clk);
        #1;
        check("pre_rst_hold", md_result, 64'd15);
        sys_rst = 1'b0;
        #1;
        check("rst_mid_done", 64'(md_done), 64'd0);
        check("rst_mid_res",  md_result,    64'd0);
        @(negedge sys_clk);
        md_valid = 1'b0;
        sys_rst  = 1'b1;

        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            word = 1'($urandom_range(0, 1));
            if (word && op != 3'd0 && !op[2]) op = 3'd0;
            a = pick();
            b = pick();
            run_op($sformatf("rnd%0d_op%0d_w%0d", i, op, word), op, word, a, b, ref_md(op, word, a, b));
        end

        @(negedge sys_clk);
        md_valid = 1'b0;
        #1;
        check("end_done", 64'(md_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
